// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches from IROM over a
// req/ack handshake, holds the word for decode and computes the next PC on commit.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        commit,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        misalign
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] NPC_BRANCH = 2'b00;
    localparam logic [1:0] NPC_JALR   = 2'b01;
    localparam logic [1:0] NPC_PC4    = 2'b10;
    localparam logic [1:0] NPC_JAL    = 2'b11;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_req;
    logic        r_misalign;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic [31:0] w_npc;

    always_comb begin
        w_pc4    = r_pc + 32'd4;
        w_target = r_pc + imm;
        w_npc    = w_pc4;
        case (npc_op)
            NPC_BRANCH: w_npc = br_taken ? w_target : w_pc4;
            NPC_JALR:   w_npc = alu_c & 32'hFFFF_FFFE;
            NPC_PC4:    w_npc = w_pc4;
            NPC_JAL:    w_npc = w_target;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_inst     <= NOP_INST;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // An ack only counts while our request is actually on the bus.
                    if (r_req && irom_ack) begin
                        r_inst  <= irom_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        r_inst  <= NOP_INST;
                        r_valid <= 1'b0;
                        if (w_npc[1:0] == 2'b00) begin
                            r_pc    <= w_npc;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_misalign <= 1'b1;
                            r_state    <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_inst  <= NOP_INST;
                end
            endcase
        end
    end

    assign irom_req   = r_req;
    assign irom_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_valid;
    assign pc         = r_pc;
    assign pc4        = w_pc4;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a driver walks a hand-computed vector table,
// a negedge monitor scoreboards fetch addresses and delivered instructions.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [1:0]  npc_op = 2'b10;
    logic        br_taken = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_c = 32'h0;
    logic        commit = 1'b0;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack = 1'b0;
    logic [31:0] irom_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .npc_op     (npc_op),
        .br_taken   (br_taken),
        .imm        (imm),
        .alu_c      (alu_c),
        .commit     (commit),
        .irom_req   (irom_req),
        .irom_addr  (irom_addr),
        .irom_ack   (irom_ack),
        .irom_rdata (irom_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .misalign   (misalign)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  waits;
        logic [1:0]  op;
        logic        br;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] nxt;
        logic        trap;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_ipc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Inputs change 2 time units after each rising edge; outputs are read there too.
    task automatic step();
        @(posedge cpu_clk);
        #2;
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, input logic [31:0] rdata,
                                 input logic [3:0] waits, input logic [1:0] op,
                                 input logic br, input logic [31:0] imm_v,
                                 input logic [31:0] alu, input logic [31:0] nxt,
                                 input logic trap);
        vec_t v;
        v.addr = addr; v.rdata = rdata; v.waits = waits; v.op = op; v.br = br;
        v.imm = imm_v; v.alu = alu; v.nxt = nxt; v.trap = trap;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_inst"}, inst, NOP_INST);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_req"}, {31'd0, irom_req}, 32'd0);
        check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        check({tag, "_pc4"}, pc4, 32'h4);
    endtask

    task automatic run_vec(input vec_t v);
        int guard;
        guard = 0;
        exp_addr_q.push_back(v.addr);
        exp_inst_q.push_back(v.rdata);
        exp_ipc_q.push_back(v.addr);
        while (!irom_req && guard < 20) begin
            step();
            guard++;
        end
        if (!irom_req) begin
            fail_now("req_timeout");
            return;
        end
        // Wait states: request must hold at the same address; commit is ignored here.
        for (int w = 0; w < int'(v.waits); w++) begin
            check("req_hold", {31'd0, irom_req}, 32'd1);
            check("req_hold_addr", irom_addr, v.addr);
            commit = 1'b1;
            npc_op = 2'b11;
            imm    = 32'h40;
            step();
        end
        commit     = 1'b0;
        irom_ack   = 1'b1;
        irom_rdata = v.rdata;
        step();
        irom_ack   = 1'b0;
        irom_rdata = 32'hDEAD_BEEF;
        check("valid_after_ack", {31'd0, inst_valid}, 32'd1);
        check("req_after_ack", {31'd0, irom_req}, 32'd0);
        step();
        check("hold_valid", {31'd0, inst_valid}, 32'd1);
        check("hold_pc", pc, v.addr);
        npc_op   = v.op;
        br_taken = v.br;
        imm      = v.imm;
        alu_c    = v.alu;
        commit   = 1'b1;
        step();
        commit = 1'b0;
        if (v.trap) begin
            check("trap_misalign", {31'd0, misalign}, 32'd1);
            check("trap_pc", pc, v.addr);
            check("trap_valid", {31'd0, inst_valid}, 32'd0);
            check("trap_inst", inst, NOP_INST);
        end else begin
            check("npc_pc", pc, v.nxt);
            check("npc_addr", irom_addr, v.nxt);
            check("npc_valid", {31'd0, inst_valid}, 32'd0);
            check("npc_inst", inst, NOP_INST);
            check("npc_misalign", {31'd0, misalign}, 32'd0);
        end
    endtask

    // Scoreboard monitor: compares on each accepted fetch and each newly valid instruction.
    initial begin : monitor
        logic prev_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        prev_valid = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (irom_req && irom_ack && !cpu_rst) begin
                if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
                else check("fetch_addr", irom_addr, exp_addr_q.pop_front());
            end
            if (inst_valid && !prev_valid) begin
                if (exp_inst_q.size() == 0) begin
                    fail_now("unexpected_inst");
                end else begin
                    e_inst = exp_inst_q.pop_front();
                    e_pc   = exp_ipc_q.pop_front();
                    check("inst_word", inst, e_inst);
                    check("inst_pc", pc, e_pc);
                    check("inst_pc4", pc4, e_pc + 32'd4);
                end
            end
            prev_valid = inst_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        vec_t vecs[13];
        vecs[0]  = mkv(32'h0000_0000, 32'h0010_0093, 4'd0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);
        vecs[1]  = mkv(32'h0000_0000, 32'h0020_0113, 4'd3, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0004, 1'b0);
        vecs[2]  = mkv(32'h0000_0004, 32'h0030_0193, 4'd0, 2'b11, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0010, 1'b0);
        vecs[3]  = mkv(32'h0000_0010, 32'hFE00_08E3, 4'd1, 2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0000_0000, 1'b0);
        vecs[4]  = mkv(32'h0000_0000, 32'h0100_006F, 4'd0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0010, 1'b0);
        vecs[5]  = mkv(32'h0000_0010, 32'hFE00_08E3, 4'd0, 2'b00, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0014, 1'b0);
        vecs[6]  = mkv(32'h0000_0014, 32'hFF5F_F06F, 4'd2, 2'b11, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h0000_0008, 1'b0);
        vecs[7]  = mkv(32'h0000_0008, 32'h1000_006F, 4'd0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0108, 1'b0);
        vecs[8]  = mkv(32'h0000_0108, 32'h0000_8067, 4'd0, 2'b01, 1'b0, 32'h0000_0000, 32'h0000_2001, 32'h0000_2000, 1'b0);
        vecs[9]  = mkv(32'h0000_2000, 32'h0000_8067, 4'd0, 2'b01, 1'b0, 32'h0000_0000, 32'h0000_2006, 32'h0000_0000, 1'b1);
        vecs[10] = mkv(32'h0000_0000, 32'hFFDF_F06F, 4'd0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
        vecs[11] = mkv(32'hFFFF_FFFC, 32'h0000_0013, 4'd1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);
        vecs[12] = mkv(32'h0000_0000, 32'h0040_0213, 4'd0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0004, 1'b0);

        step();
        step();
        check_reset_state("reset");
        cpu_rst = 1'b0;

        for (int i = 0; i <= 9; i++) run_vec(vecs[i]);

        // Halted: neither ack nor commit may revive the unit.
        for (int c = 0; c < 10; c++) begin
            irom_ack = 1'b1;
            commit   = 1'b1;
            step();
            check("halt_req", {31'd0, irom_req}, 32'd0);
            check("halt_pc", pc, 32'h0000_2000);
            check("halt_misalign", {31'd0, misalign}, 32'd1);
            check("halt_valid", {31'd0, inst_valid}, 32'd0);
        end
        irom_ack = 1'b0;
        commit   = 1'b0;
        cpu_rst  = 1'b1;
        step();
        check_reset_state("trap_reset");
        cpu_rst = 1'b0;

        run_vec(vecs[10]);
        run_vec(vecs[11]);

        // Reset lands on the same edge as an ack: the fetch must be abandoned.
        check("midfetch_req_up", {31'd0, irom_req}, 32'd1);
        cpu_rst    = 1'b1;
        irom_ack   = 1'b1;
        irom_rdata = 32'hCAFE_F00D;
        step();
        cpu_rst  = 1'b0;
        irom_ack = 1'b0;
        check_reset_state("midfetch_reset");

        run_vec(vecs[12]);

        step();
        check("queues_drained", exp_addr_q.size() + exp_inst_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder/controller.
- Holds the architectural PC and fetches instructions from IROM over a request/acknowledge handshake.
- Presents the instruction and its PC to decode, and computes the next PC from the controller's npc_op, the branch flag, the sign-extended immediate and the ALU result.
- Traps on a misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word driven on inst while no valid instruction is held.

Ports:
- cpu_clk  in  1  system clock; all state updates on rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- npc_op  in  2  next-PC select from controller: 00 branch, 01 jalr, 10 pc+4, 11 jal.
- br_taken  in  1  branch condition from ALU; used only when npc_op=00.
- imm  in  32  sign-extended immediate from SEXT.
- alu_c  in  32  ALU result; used as the jalr target.
- commit  in  1  downstream has finished executing the held instruction.
- irom_req  out  1  fetch request.
- irom_addr  out  32  fetch address, equal to pc.
- irom_ack  in  1  IROM response valid; irom_rdata is valid in this cycle.
- irom_rdata  in  32  fetched instruction word.
- inst  out  32  held instruction word, sent to decode.
- inst_valid  out  1  inst/pc describe a live instruction.
- pc  out  32  PC of the held/requested instruction.
- pc4  out  32  pc+4, combinational from the pc register; used for the rf_wsel link value.
- misalign  out  1  sticky error flag.

Behaviour:
- Clocking/reset: one clock (cpu_clk); reset is synchronous and active-high (cpu_rst), sampled only on a rising edge of cpu_clk.
- Reset values: pc=RESET_PC, inst=NOP_INST, inst_valid=0, irom_req=0, misalign=0, state=S_REQ (entered on the first cycle after reset deasserts).
- Reset mid-operation: reset wins over every other input in the same cycle and abandons any outstanding fetch. irom_ack arriving while irom_req=0 is ignored.
- State S_REQ:
  - irom_req=1, irom_addr=pc, inst_valid=0.
  - Stay in S_REQ while irom_ack=0; there is no timeout.
  - When irom_ack=1: inst<=irom_rdata, inst_valid<=1, state<=S_EXEC.
  - irom_req is registered, so it deasserts in the cycle after the ack.
- State S_EXEC:
  - irom_req=0, inst_valid=1, pc is stable.
  - commit=0: hold all outputs.
  - commit=1: compute npc (below).
    - If npc[1:0]==2'b00: pc<=npc, inst<=NOP_INST, inst_valid<=0, state<=S_REQ.
    - Otherwise: misalign<=1, state<=S_HALT, pc unchanged.
- commit is ignored in S_REQ and S_HALT.
- Next-PC arithmetic (32-bit, modulo 2^32, wrap-around allowed without error):
  - npc_op=00: pc+imm if br_taken=1, else pc+4.
  - npc_op=01: alu_c & 32'hFFFF_FFFE.
  - npc_op=10: pc+4.
  - npc_op=11: pc+imm.
- Misalign check: applied to the final npc after the jalr bit-0 clear. A jalr target with bit 1 set traps.
- State S_HALT: irom_req=0, inst_valid=0, inst=NOP_INST, misalign=1. Only cpu_rst exits this state.
- Throughput: with a zero-wait IROM (ack in the first S_REQ cycle) and commit asserted as soon as inst_valid=1, each instruction takes 2 cycles.
- pc4 is always pc+4, including in S_REQ and S_HALT.

Test Plan:
- Reset/first fetch: hold cpu_rst 2 cycles; release; ack with rdata=32'h0010_0093 in the same cycle -> irom_addr=0 during the request; next cycle inst=32'h0010_0093, inst_valid=1, irom_req=0, pc4=4.
- Sequential with wait states: ack delayed 3 cycles; commit with npc_op=10 -> irom_req held 4 cycles at addr 0; after commit pc=4, irom_addr=4.
- Branch: pc=32'h10, npc_op=00, imm=32'hFFFF_FFF0.
  - br_taken=1 -> pc=0.
  - Repeat with br_taken=0 -> pc=32'h14.
- JAL and JALR:
  - pc=8, npc_op=11, imm=32'h100 -> pc=32'h108.
  - npc_op=01, alu_c=32'h0000_2001 -> pc=32'h2000.
- Misalign and wrap:
  - npc_op=01, alu_c=32'h0000_2006 -> misalign=1, irom_req stays 0 for 10 cycles, pc unchanged; cpu_rst clears the trap.
  - pc=32'hFFFF_FFFC with npc_op=10 -> pc=0, misalign=0.
- Reset mid-fetch: assert cpu_rst during S_REQ while irom_ack=1 -> inst_valid stays 0, pc=RESET_PC, inst=NOP_INST, and a fresh request is issued at addr 0.
